// File: rtl/arp_tx_frame.sv
// ---------------------------------------------------------------------------
// arp_tx_frame
// Emits one Ethernet II broadcast ARP request per accepted tx_start as a GMII
// byte stream (preamble, SFD, 60 data bytes incl. padding, 4-byte FCS), then
// holds off for IFG idle cycles. Drives the downstream CRC32 (D8) block's
// init/enable and builds the FCS from its registered CRC.
//
// Ports:
//   clk, rst_n      GMII tx clock, async active-low reset
//   tx_start        start request, sampled only when idle
//   dst_ip[31:0]    ARP target IP, latched on accepted tx_start
//   crc[31:0]       running CRC from the downstream calculator
//   gmii_tx_en      frame valid
//   gmii_txd[7:0]   frame byte
//   crc_en          CRC accumulate enable (data bytes only)
//   crc_init        CRC reset-to-ones request (during preamble)
//   tx_busy         first preamble byte until end of inter-frame gap
//   tx_done         one-cycle pulse after the last FCS byte
//
// state       | meaning
// ST_IDLE     | waiting for tx_start
// ST_PREAMBLE | 7 x 0x55 then SFD 0xD5, CRC held in init
// ST_DATA     | 60 header/ARP/pad bytes, CRC accumulating
// ST_FCS      | 4 FCS bytes taken from the frozen CRC
// ST_GAP      | IFG idle cycles before the next frame may start
// ---------------------------------------------------------------------------
module arp_tx_frame #(
    parameter logic [47:0] SRC_MAC = 48'h000A3501FEC0,
    parameter logic [31:0] SRC_IP  = 32'hC0A80002,
    parameter int          IFG     = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_start,
    input  logic [31:0] dst_ip,
    input  logic [31:0] crc,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd,
    output logic        crc_en,
    output logic        crc_init,
    output logic        tx_busy,
    output logic        tx_done
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_PREAMBLE, ST_DATA, ST_FCS, ST_GAP
    } state_t;

    localparam logic [6:0] GAP_LAST = 7'(IFG - 1);

    state_t      state, state_nxt;
    logic [6:0]  cnt, cnt_nxt;
    logic [31:0] dst_ip_q;
    logic [7:0]  txd_q, txd_nxt;
    logic        tx_en_nxt, crc_en_nxt, crc_init_nxt, busy_nxt, done_nxt;
    logic [7:0]  fcs_byte;

    function automatic logic [7:0] rev8(input logic [7:0] x);
        for (int i = 0; i < 8; i++) rev8[i] = x[7-i];
    endfunction

    // Data byte idx (0..59) of the frame after the SFD.
    function automatic logic [7:0] data_byte(input logic [6:0] idx, input logic [31:0] tpa);
        data_byte = 8'h00;
        case (idx) inside
            [7'd0:7'd5]:   data_byte = 8'hFF;
            [7'd6:7'd11]:  data_byte = 8'(SRC_MAC >> {7'd11 - idx, 3'b000});
            7'd12:         data_byte = 8'h08;
            7'd13:         data_byte = 8'h06;
            7'd15:         data_byte = 8'h01;
            7'd16:         data_byte = 8'h08;
            7'd18:         data_byte = 8'h06;
            7'd19:         data_byte = 8'h04;
            7'd21:         data_byte = 8'h01;
            [7'd22:7'd27]: data_byte = 8'(SRC_MAC >> {7'd27 - idx, 3'b000});
            [7'd28:7'd31]: data_byte = 8'(SRC_IP >> {7'd31 - idx, 3'b000});
            [7'd38:7'd41]: data_byte = 8'(tpa >> {7'd41 - idx, 3'b000});
            default:       data_byte = 8'h00;
        endcase
    endfunction

    // State, counter, latch and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            dst_ip_q   <= '0;
            txd_q      <= '0;
            gmii_tx_en <= 1'b0;
            crc_en     <= 1'b0;
            crc_init   <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            if (state == ST_IDLE && tx_start)
                dst_ip_q <= dst_ip;
            txd_q      <= txd_nxt;
            gmii_tx_en <= tx_en_nxt;
            crc_en     <= crc_en_nxt;
            crc_init   <= crc_init_nxt;
            tx_busy    <= busy_nxt;
            tx_done    <= done_nxt;
        end
    end

    // Next state; cnt indexes the byte being shown in the current state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 7'd1;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (tx_start) state_nxt = ST_PREAMBLE;
            end
            ST_PREAMBLE: if (cnt == 7'd7) begin
                state_nxt = ST_DATA;
                cnt_nxt   = '0;
            end
            ST_DATA: if (cnt == 7'd59) begin
                state_nxt = ST_FCS;
                cnt_nxt   = '0;
            end
            ST_FCS: if (cnt == 7'd3) begin
                state_nxt = ST_GAP;
                cnt_nxt   = '0;
            end
            ST_GAP: if (cnt == GAP_LAST) begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output values for the upcoming cycle, registered above.
    always_comb begin
        txd_nxt      = 8'h00;
        tx_en_nxt    = state_nxt inside {ST_PREAMBLE, ST_DATA, ST_FCS};
        crc_en_nxt   = (state_nxt == ST_DATA);
        crc_init_nxt = (state_nxt == ST_PREAMBLE);
        busy_nxt     = (state_nxt != ST_IDLE);
        done_nxt     = (state == ST_FCS) && (state_nxt == ST_GAP);
        case (state_nxt)
            ST_PREAMBLE: txd_nxt = (cnt_nxt == 7'd7) ? 8'hD5 : 8'h55;
            ST_DATA:     txd_nxt = data_byte(cnt_nxt, dst_ip_q);
            default:     txd_nxt = 8'h00;
        endcase
    end

    // The CRC only covers the last data byte from the first FCS cycle on, so
    // FCS bytes cannot be pre-registered; they are muxed straight from the
    // (registered, frozen) crc input instead.
    always_comb begin
        case (cnt[1:0])
            2'd0:    fcs_byte = ~rev8(crc[31:24]);
            2'd1:    fcs_byte = ~rev8(crc[23:16]);
            2'd2:    fcs_byte = ~rev8(crc[15:8]);
            default: fcs_byte = ~rev8(crc[7:0]);
        endcase
    end

    assign gmii_txd = (state == ST_FCS) ? fcs_byte : txd_q;

endmodule

// File: tb/tb_arp_tx_frame.sv
module tb_arp_tx_frame;

    localparam logic [47:0] SRC_MAC = 48'h000A3501FEC0;
    localparam logic [31:0] SRC_IP  = 32'hC0A80002;
    localparam int          IFG     = 12;

    logic clk, rst_n;
    logic tx_start, tx_start1;
    logic [31:0] dst_ip, dst_ip1;
    logic [31:0] crc, crc1;
    logic tx_en, crc_en, crc_init, tx_busy, tx_done;
    logic tx_en1, crc_en1, crc_init1, tx_busy1, tx_done1;
    logic [7:0] txd, txd1;
    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    arp_tx_frame #(.SRC_MAC(SRC_MAC), .SRC_IP(SRC_IP), .IFG(IFG)) dut (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .dst_ip(dst_ip), .crc(crc),
        .gmii_tx_en(tx_en), .gmii_txd(txd), .crc_en(crc_en), .crc_init(crc_init),
        .tx_busy(tx_busy), .tx_done(tx_done));

    arp_tx_frame #(.SRC_MAC(SRC_MAC), .SRC_IP(SRC_IP), .IFG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start1), .dst_ip(dst_ip1), .crc(crc1),
        .gmii_tx_en(tx_en1), .gmii_txd(txd1), .crc_en(crc_en1), .crc_init(crc_init1),
        .tx_busy(tx_busy1), .tx_done(tx_done1));

    initial clk = 1'b0;
    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream CRC32 D8 calculator: MSB-first register, byte bits fed LSB first.
    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        logic fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0};
            if (fb) c = c ^ 32'h04C11DB7;
        end
        return c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc  <= 32'hFFFFFFFF;
            crc1 <= 32'hFFFFFFFF;
        end else begin
            if (crc_init) crc <= 32'hFFFFFFFF;
            else if (crc_en) crc <= crc_step(crc, txd);
            if (crc_init1) crc1 <= 32'hFFFFFFFF;
            else if (crc_en1) crc1 <= crc_step(crc1, txd1);
        end
    end

    // Reference frame: 72 bytes on the wire, first byte in the top bits.
    function automatic logic [575:0] build_frame(input logic [31:0] ip);
        logic [479:0] body;
        logic [31:0]  c;
        body = {48'hFFFFFFFFFFFF, SRC_MAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
                16'h0001, SRC_MAC, SRC_IP, 48'h0, ip, 144'h0};
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 60; i++) begin
            c = c ^ {24'h0, body[479-8*i -: 8]};
            for (int j = 0; j < 8; j++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        return {56'h55555555555555, 8'hD5, body, c[7:0], c[15:8], c[23:16], c[31:24]};
    endfunction

    function automatic logic [7:0] exp_byte(input logic [575:0] f, input int i);
        return f[575-8*i -: 8];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Entered after a negedge in C0 with tx_start already driven high.
    // Leaves just after the negedge of cycle C73+IFG.
    task automatic check_frame(input logic [31:0] ip, input bit inject);
        logic [575:0] f;
        f = build_frame(ip);
        @(posedge clk); #1 tx_start = 1'b0;
        for (int k = 1; k <= 72 + IFG; k++) begin
            if (inject) begin
                if (k == 20 || k == 73) tx_start = 1'b1;
                if (k == 21 || k == 74) tx_start = 1'b0;
                if (k == 30) dst_ip = 32'hFFFFFFFF;
            end
            @(negedge clk);
            check($sformatf("txd k=%0d", k), {24'h0, txd},
                  (k <= 72) ? {24'h0, exp_byte(f, k-1)} : 32'h0);
            check($sformatf("ctl{en,crc_en,init,busy,done} k=%0d", k),
                  {27'h0, tx_en, crc_en, crc_init, tx_busy, tx_done},
                  {27'h0, k <= 72, k >= 9 && k <= 68, k <= 8, 1'b1, k == 73});
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("busy_release", {30'h0, tx_busy, tx_en}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ip;
        logic [575:0] f1;
        int pos, en_cnt;
        bit prev;
        int rises[$];

        rst_n = 1'b0; tx_start = 1'b0; tx_start1 = 1'b0;
        dst_ip = '0; dst_ip1 = '0;
        #20;
        check("rst tx_en",    {31'h0, tx_en},    32'h0);
        check("rst txd",      {24'h0, txd},      32'h0);
        check("rst crc_en",   {31'h0, crc_en},   32'h0);
        check("rst crc_init", {31'h0, crc_init}, 32'h0);
        check("rst tx_busy",  {31'h0, tx_busy},  32'h0);
        check("rst tx_done",  {31'h0, tx_done},  32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame with start-while-busy pulses and dst_ip change mid-frame,
        // then a chained frame started in the first idle cycle.
        tx_start = 1'b1; dst_ip = 32'hC0A80003;
        check_frame(32'hC0A80003, 1'b1);
        ip = $urandom; tx_start = 1'b1; dst_ip = ip;
        check_frame(ip, 1'b0);

        for (int n = 0; n < 3; n++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            ip = $urandom; tx_start = 1'b1; dst_ip = ip;
            check_frame(ip, 1'b0);
        end

        // Async reset at C40.
        @(negedge clk);
        tx_start = 1'b1; dst_ip = $urandom;
        @(posedge clk); #1 tx_start = 1'b0;
        repeat (39) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst tx_en",    {31'h0, tx_en},    32'h0);
        check("arst txd",      {24'h0, txd},      32'h0);
        check("arst crc_en",   {31'h0, crc_en},   32'h0);
        check("arst crc_init", {31'h0, crc_init}, 32'h0);
        check("arst tx_busy",  {31'h0, tx_busy},  32'h0);
        check("arst tx_done",  {31'h0, tx_done},  32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        en_cnt = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (tx_en || tx_busy) en_cnt++;
        end
        check("no_output_after_rst", 32'(en_cnt), 32'h0);
        ip = $urandom; tx_start = 1'b1; dst_ip = ip;
        check_frame(ip, 1'b0);

        // IFG=1 instance with tx_start held high.
        ip = $urandom; dst_ip1 = ip; f1 = build_frame(ip);
        @(negedge clk);
        tx_start1 = 1'b1;
        prev = 1'b0; pos = 0;
        for (int n = 0; n < 320; n++) begin
            @(negedge clk);
            if (tx_en1 && !prev) begin
                rises.push_back(cyc);
                pos = 0;
            end
            if (tx_en1) begin
                if (pos < 72) check($sformatf("hold txd pos=%0d", pos), {24'h0, txd1},
                                    {24'h0, exp_byte(f1, pos)});
                pos++;
            end
            if (!tx_en1 && prev) check("hold frame_len", 32'(pos), 32'd72);
            prev = tx_en1;
        end
        tx_start1 = 1'b0;
        check("hold frame_count>=4", {31'h0, rises.size() >= 4}, 32'h1);
        for (int i = 1; i < rises.size(); i++)
            check($sformatf("hold period %0d", i), 32'(rises[i] - rises[i-1]), 32'd74);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
